// File: rtl/cp0_regfile.sv
// MIPS32 coprocessor-0 register file: BadVAddr, Count, Compare, Status, Cause, EPC,
// exception/eret commit, mtc0 writes and the Count/Compare timer interrupt.
module cp0_regfile #(
  parameter int COUNT_HALF = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  input  logic [5:0]  int_i,
  input  logic        except_valid,
  input  logic [31:0] except_type,
  input  logic [31:0] pc,
  input  logic        in_delayslot,
  input  logic [31:0] bad_addr,
  output logic [31:0] rdata,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic        timer_int
);

  localparam logic [4:0]  ADDR_BADVADDR = 5'd8;
  localparam logic [4:0]  ADDR_COUNT    = 5'd9;
  localparam logic [4:0]  ADDR_COMPARE  = 5'd11;
  localparam logic [4:0]  ADDR_STATUS   = 5'd12;
  localparam logic [4:0]  ADDR_CAUSE    = 5'd13;
  localparam logic [4:0]  ADDR_EPC      = 5'd14;
  localparam logic [31:0] EXC_ADEL      = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES      = 32'h0000_0005;
  localparam logic [31:0] EXC_ERET      = 32'h0000_000E;
  localparam logic [31:0] STATUS_RESET  = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK  = 32'h0000_FF03;

  logic [31:0] badVAddr;
  logic [31:0] count;
  logic [31:0] compare;
  logic [31:0] status;
  logic [31:0] epc;
  logic        causeBd;
  logic        causeTi;
  logic [5:0]  causeIpHw;
  logic [1:0]  causeIpSw;
  logic [4:0]  excCode;
  logic        toggle;

  logic mtc0Write;
  logic isEret;
  logic isExc;
  logic compareHit;
  logic countInc;
  logic tiNext;

  // An exception or eret in the same cycle drops the mtc0 entirely.
  assign mtc0Write  = we && !except_valid;
  assign isEret     = except_valid && (except_type == EXC_ERET);
  assign isExc      = except_valid && !isEret;
  assign compareHit = (count == compare) && (compare != 32'd0);
  assign countInc   = (COUNT_HALF != 0) ? toggle : 1'b1;

  always_comb begin
    tiNext = causeTi;
    if (mtc0Write && waddr == ADDR_COMPARE) tiNext = 1'b0;
    else if (compareHit)                    tiNext = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      badVAddr  <= 32'd0;
      count     <= 32'd0;
      compare   <= 32'd0;
      status    <= STATUS_RESET;
      epc       <= 32'd0;
      causeBd   <= 1'b0;
      causeTi   <= 1'b0;
      causeIpHw <= 6'd0;
      causeIpSw <= 2'd0;
      excCode   <= 5'd0;
      toggle    <= 1'b0;
    end else begin
      toggle    <= ~toggle;
      causeTi   <= tiNext;
      // IP7 shares the line with the timer so the Cause word stays self-consistent.
      causeIpHw <= {int_i[5] | tiNext, int_i[4:0]};

      if (mtc0Write && waddr == ADDR_COUNT) count <= wdata;
      else if (countInc)                    count <= count + 32'd1;

      if (isEret) begin
        status[1] <= 1'b0;
      end else if (isExc) begin
        if (!status[1]) begin
          epc     <= in_delayslot ? pc - 32'd4 : pc;
          causeBd <= in_delayslot;
        end
        status[1] <= 1'b1;
        excCode   <= except_type[4:0];
        if (except_type == EXC_ADEL || except_type == EXC_ADES) badVAddr <= bad_addr;
      end else if (mtc0Write) begin
        case (waddr)
          ADDR_COMPARE: compare   <= wdata;
          ADDR_STATUS:  status    <= (status & ~STATUS_WMASK) | (wdata & STATUS_WMASK);
          ADDR_CAUSE:   causeIpSw <= wdata[9:8];
          ADDR_EPC:     epc       <= wdata;
          default:      ;
        endcase
      end
    end
  end

  assign status_o  = status;
  assign cause_o   = {causeBd, causeTi, 14'd0, causeIpHw, causeIpSw, 1'b0, excCode, 2'b00};
  assign epc_o     = epc;
  assign timer_int = causeTi;

  always_comb begin
    rdata = 32'd0;
    case (raddr)
      ADDR_BADVADDR: rdata = badVAddr;
      ADDR_COUNT:    rdata = count;
      ADDR_COMPARE:  rdata = compare;
      ADDR_STATUS:   rdata = status_o;
      ADDR_CAUSE:    rdata = cause_o;
      ADDR_EPC:      rdata = epc_o;
      default:       rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Bench for cp0_regfile: directed vector table, hand-written timer/reset sequences,
// and randomized traffic checked against a field-level reference model.
module tb_cp0_regfile;

  localparam int COUNT_HALF = 1;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [5:0]  int_i;
  logic        except_valid;
  logic [31:0] except_type;
  logic [31:0] pc;
  logic        in_delayslot;
  logic [31:0] bad_addr;
  logic [31:0] rdata;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic        timer_int;

  cp0_regfile #(.COUNT_HALF(COUNT_HALF)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .int_i(int_i), .except_valid(except_valid), .except_type(except_type), .pc(pc),
    .in_delayslot(in_delayslot), .bad_addr(bad_addr), .rdata(rdata), .status_o(status_o),
    .cause_o(cause_o), .epc_o(epc_o), .timer_int(timer_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference model: architectural fields, Count derived from edge parity since reset.
  int          mEdges;
  logic [31:0] mCount, mCompare, mEpc, mBadV;
  logic [7:0]  mIm;
  logic        mExl, mIe, mBd, mTi;
  logic [5:0]  mIp;
  logic [1:0]  mSwIp;
  logic [4:0]  mExc;

  task automatic modelReset();
    mEdges = 0; mCount = 0; mCompare = 0; mEpc = 0; mBadV = 0;
    mIm = 0; mExl = 0; mIe = 0; mBd = 0; mTi = 0; mIp = 0; mSwIp = 0; mExc = 0;
  endtask

  task automatic modelEdge();
    logic        wr;
    logic        hit;
    logic [31:0] nCount;
    mEdges++;
    wr  = we && !except_valid;
    hit = (mCount == mCompare) && (mCompare != 0);
    nCount = mCount + ((COUNT_HALF == 0 || mEdges % 2 == 0) ? 32'd1 : 32'd0);
    if (wr && waddr == 5'd9) nCount = wdata;
    if (wr && waddr == 5'd11) begin
      mTi = 1'b0;
      mCompare = wdata;
    end else if (hit) mTi = 1'b1;
    mCount = nCount;
    mIp = {int_i[5] | mTi, int_i[4:0]};
    if (except_valid) begin
      if (except_type == 32'hE) mExl = 1'b0;
      else begin
        if (!mExl) begin
          mEpc = in_delayslot ? pc - 32'd4 : pc;
          mBd  = in_delayslot;
        end
        mExl = 1'b1;
        mExc = except_type[4:0];
        if (except_type == 32'h4 || except_type == 32'h5) mBadV = bad_addr;
      end
    end else if (we) begin
      if (waddr == 5'd12) begin mIm = wdata[15:8]; mExl = wdata[1]; mIe = wdata[0]; end
      if (waddr == 5'd13) mSwIp = wdata[9:8];
      if (waddr == 5'd14) mEpc = wdata;
    end
  endtask

  function automatic logic [31:0] mStatus();
    return 32'h0040_0000 + (32'(mIm) << 8) + (32'(mExl) << 1) + 32'(mIe);
  endfunction

  function automatic logic [31:0] mCause();
    return (32'(mBd) << 31) + (32'(mTi) << 30) + (32'(mIp) << 10) + (32'(mSwIp) << 8) + (32'(mExc) << 2);
  endfunction

  function automatic logic [31:0] mRead(input logic [4:0] a);
    case (a)
      5'd8:    return mBadV;
      5'd9:    return mCount;
      5'd11:   return mCompare;
      5'd12:   return mStatus();
      5'd13:   return mCause();
      5'd14:   return mEpc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(input logic iWe, input logic [4:0] iWaddr, input logic [31:0] iWdata,
                       input logic [4:0] iRaddr, input logic [5:0] iInt, input logic iExv,
                       input logic [31:0] iType, input logic [31:0] iPc, input logic iDs,
                       input logic [31:0] iBad);
    we = iWe; waddr = iWaddr; wdata = iWdata; raddr = iRaddr; int_i = iInt;
    except_valid = iExv; except_type = iType; pc = iPc; in_delayslot = iDs; bad_addr = iBad;
  endtask

  task automatic idle(input logic [4:0] r);
    drive(1'b0, 5'd0, 32'd0, r, 6'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
  endtask

  // One rising edge; the model steps on the same pre-edge inputs, outputs sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        exv;
    logic [31:0] etype;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] bad;
    logic [4:0]  raddr;
    logic [31:0] expRdata;
    logic [31:0] expStatus;
    logic [31:0] expCause;
    logic [31:0] expEpc;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] types[8];
    logic [4:0]  addrs[8];
    types = '{32'h0, 32'h4, 32'h5, 32'h8, 32'h9, 32'hA, 32'hC, 32'hE};
    addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3, 5'd31};

    vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b1, 32'h8, 32'hBFC0_0104, 1'b1, 32'h0, 5'd14,
                 32'hBFC0_0100, 32'h0040_0002, 32'h8000_0020, 32'hBFC0_0100};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 32'hE, 32'h0,         1'b0, 32'h0, 5'd12,
                 32'h0040_0000, 32'h0040_0000, 32'h8000_0020, 32'hBFC0_0100};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 32'h4, 32'h8000_0010, 1'b0, 32'h3, 5'd8,
                 32'h0000_0003, 32'h0040_0002, 32'h0000_0010, 32'h8000_0010};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 32'h8, 32'h8000_0040, 1'b1, 32'h7, 5'd14,
                 32'h8000_0010, 32'h0040_0002, 32'h0000_0020, 32'h8000_0010};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 32'hE, 32'h0,         1'b0, 32'h0, 5'd13,
                 32'h0000_0020, 32'h0040_0000, 32'h0000_0020, 32'h8000_0010};
    vecs[5]  = '{1'b1, 5'd12, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0,        1'b0, 32'h0, 5'd12,
                 32'h0040_FF03, 32'h0040_FF03, 32'h0000_0020, 32'h8000_0010};
    vecs[6]  = '{1'b1, 5'd13, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0,        1'b0, 32'h0, 5'd13,
                 32'h0000_0320, 32'h0040_FF03, 32'h0000_0320, 32'h8000_0010};
    vecs[7]  = '{1'b1, 5'd8,  32'h0000_DEAD, 1'b0, 32'h0, 32'h0,        1'b0, 32'h0, 5'd8,
                 32'h0000_0003, 32'h0040_FF03, 32'h0000_0320, 32'h8000_0010};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 32'hE, 32'h0,         1'b0, 32'h0, 5'd12,
                 32'h0040_FF01, 32'h0040_FF01, 32'h0000_0320, 32'h8000_0010};
    vecs[9]  = '{1'b1, 5'd14, 32'h0000_1234, 1'b1, 32'hC, 32'h8000_0020, 1'b0, 32'h0, 5'd14,
                 32'h8000_0020, 32'h0040_FF03, 32'h0000_0330, 32'h8000_0020};
    vecs[10] = '{1'b1, 5'd14, 32'h0000_1234, 1'b0, 32'h0, 32'h0,        1'b0, 32'h0, 5'd14,
                 32'h0000_1234, 32'h0040_FF03, 32'h0000_0330, 32'h0000_1234};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0, 32'h0,         1'b0, 32'h0, 5'd5,
                 32'h0000_0000, 32'h0040_FF03, 32'h0000_0330, 32'h0000_1234};

    rst = 1'b0;
    idle(5'd12);
    modelReset();
    repeat (3) @(negedge clk);
    check("reset.status", status_o, 32'h0040_0000);
    check("reset.cause", cause_o, 32'h0);
    check("reset.epc", epc_o, 32'h0);
    check("reset.timer", 32'(timer_int), 32'h0);
    check("reset.rdata", rdata, 32'h0040_0000);
    rst = 1'b1;

    idle(5'd9);
    tick();
    check("count.after1", rdata, 32'd0);
    tick();
    check("count.after2", rdata, 32'd1);

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].raddr, 6'd0, vecs[i].exv,
            vecs[i].etype, vecs[i].pc, vecs[i].ds, vecs[i].bad);
      tick();
      check($sformatf("vec%0d.rdata", i), rdata, vecs[i].expRdata);
      check($sformatf("vec%0d.status", i), status_o, vecs[i].expStatus);
      check($sformatf("vec%0d.cause", i), cause_o, vecs[i].expCause);
      check($sformatf("vec%0d.epc", i), epc_o, vecs[i].expEpc);
    end

    drive(1'b1, 5'd11, 32'd5, 5'd11, 6'd0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 5'd9, 32'd0, 5'd9, 6'd0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    check("timer.countZero", rdata, 32'd0);
    idle(5'd9);
    begin
      int n = 0;
      while (!timer_int && n < 40) begin
        tick();
        n++;
      end
    end
    check("timer.set", 32'(timer_int), 32'd1);
    check("timer.ip7", 32'(cause_o[15]), 32'd1);
    check("timer.ti", 32'(cause_o[30]), 32'd1);
    check("timer.count", rdata, 32'd5);
    tick();
    check("timer.sticky", 32'(timer_int), 32'd1);
    drive(1'b1, 5'd11, 32'h100, 5'd11, 6'd0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    check("timer.clear", 32'(timer_int), 32'd0);
    check("timer.ip7clear", 32'(cause_o[15]), 32'd0);

    idle(5'd9);
    repeat (5) tick();
    #2;
    rst = 1'b0;
    #1;
    modelReset();
    check("arst.count", rdata, 32'd0);
    check("arst.status", status_o, 32'h0040_0000);
    check("arst.cause", cause_o, 32'h0);
    check("arst.epc", epc_o, 32'h0);
    check("arst.timer", 32'(timer_int), 32'h0);
    raddr = 5'd11;
    #1;
    check("arst.compare", rdata, 32'h0);
    raddr = 5'd8;
    #1;
    check("arst.badvaddr", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 500; k++) begin
      logic [31:0] d;
      case ($urandom_range(0, 3))
        0:       d = $urandom;
        1:       d = 32'hFFFF_FFFF;
        default: d = $urandom_range(0, 12);
      endcase
      drive(($urandom_range(0, 9) < 3), addrs[$urandom_range(0, 7)], d,
            addrs[$urandom_range(0, 7)], 6'($urandom_range(0, 63)), ($urandom_range(0, 9) < 2),
            types[$urandom_range(0, 7)], $urandom, 1'($urandom_range(0, 1)), $urandom);
      tick();
      check($sformatf("rnd%0d.rdata", k), rdata, mRead(raddr));
      check($sformatf("rnd%0d.status", k), status_o, mStatus());
      check($sformatf("rnd%0d.cause", k), cause_o, mCause());
      check($sformatf("rnd%0d.epc", k), epc_o, mEpc);
      check($sformatf("rnd%0d.timer", k), 32'(timer_int), 32'(mTi));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
